spi_slave: RTL and testbench

SPI peripheral-side (responder) byte engine: oversamples an external SPI master's SCLK/MOSI/CS_n on the system clock and assembles received bytes MSB first. It shifts out a host-supplied byte on MISO in the same frame, in any of the four SPI modes. It sits between the board-level SPI pins and on-chip register/command logic, acting as the counterpart to the team's SPI master.

---
 rtl/spi_slave.sv | 170 +++++++++++++++++
 tb/tb_spi_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI responder byte engine: oversamples SCLK/MOSI/CS_n and exchanges
// MSB-first bytes in all four SPI modes through a one-byte tx holding register.
module spi_slave #(
   parameter logic [7:0] FILL_BYTE = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] mode,
   input  logic       spi_sclk,
   input  logic       spi_mosi,
   input  logic       spi_cs_n,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_underrun,
   output logic       busy
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t     state_q, state_d;
   logic [2:0] sclk_q, cs_q;
   logic [1:0] mosi_q;
   logic [1:0] mode_q, mode_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] rx_sh_q, rx_sh_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic       miso_q, miso_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       undr_q, undr_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;

   logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic       lead_edge, trail_edge, sample_edge, shift_edge;
   logic       load, start;
   logic [7:0] load_byte;

   // [0],[1] form the 2-FF synchroniser, [2] is stage 2 delayed for edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= '0;
         cs_q   <= '0;
         mosi_q <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], spi_sclk};
         cs_q   <= {cs_q[1:0], spi_cs_n};
         mosi_q <= {mosi_q[0], spi_mosi};
      end
   end

   assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
   assign cs_fall     = ~cs_q[1] & cs_q[2];
   assign cs_rise     = cs_q[1] & ~cs_q[2];
   assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
   assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
   assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
   assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mode_q      <= '0;
         bit_cnt_q   <= '0;
         rx_sh_q     <= '0;
         tx_sh_q     <= '0;
         miso_q      <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         undr_q      <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_sh_q     <= rx_sh_d;
         tx_sh_q     <= tx_sh_d;
         miso_q      <= miso_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         undr_q      <= undr_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      bit_cnt_d   = bit_cnt_q;
      rx_sh_d     = rx_sh_q;
      tx_sh_d     = tx_sh_q;
      miso_d      = miso_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      undr_d      = 1'b0;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      load        = 1'b0;
      start       = 1'b0;
      load_byte   = FILL_BYTE;

      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d   = ACTIVE;
               mode_d    = mode;
               bit_cnt_d = '0;
               load      = 1'b1;
               start     = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
            end else if (sample_edge) begin
               rx_sh_d   = {rx_sh_q[5:0], mosi_q[1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = {rx_sh_q, mosi_q[1]};
                  rx_valid_d = 1'b1;
                  load       = 1'b1;
               end
            end else if (shift_edge) begin
               miso_d  = tx_sh_q[7];
               tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
         end
         default: ;
      endcase

      // A write landing this cycle goes to holding, never straight to the shifter
      if (load) begin
         if (hold_full_q) begin
            load_byte   = hold_q;
            hold_full_d = 1'b0;
         end else begin
            undr_d = 1'b1;
         end
         if (start && !mode[0]) begin
            miso_d  = load_byte[7];
            tx_sh_d = {load_byte[6:0], 1'b0};
         end else begin
            tx_sh_d = load_byte;
         end
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = (state_q == ACTIVE);
   assign busy        = (state_q == ACTIVE);
   assign tx_ready    = ~hold_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = undr_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-level SPI master model with scoreboard
// queues for bytes received by the DUT and by the master.
module tb_spi_slave;

   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mode;
   logic       spi_sclk, spi_mosi, spi_cs_n;
   logic       spi_miso, spi_miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, tx_underrun, busy;

   int n_cmp = 0;
   int n_err = 0;
   int rxv = 0;
   int uc = 0;
   int ul = 0;
   int u0, r0;

   logic [7:0] exp_rx[$];
   logic [7:0] exp_miso[$];
   logic [7:0] mo[4];

   spi_slave dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .spi_sclk   (spi_sclk),
      .spi_mosi   (spi_mosi),
      .spi_cs_n   (spi_cs_n),
      .spi_miso   (spi_miso),
      .spi_miso_oe(spi_miso_oe),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_underrun(tx_underrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [7:0] e;
      if (rx_valid) begin
         rxv++;
         if (exp_rx.size() == 0) begin
            chk("rx_unexpected", 1, 0);
         end else begin
            e = exp_rx.pop_front();
            chk("rx_data", rx_data, e);
         end
      end
      if (tx_underrun) uc++;
   end

   task automatic wr(input logic [7:0] b);
      @(negedge clk);
      chk("tx_ready_pre", tx_ready, 1);
      tx_valid = 1'b1;
      tx_data  = b;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("tx_ready_fall", tx_ready, 0);
   endtask

   task automatic idle_lvl(input logic [1:0] m);
      spi_sclk = m[1];
      repeat (HALF) @(negedge clk);
   endtask

   task automatic half_wait(input bit t, input logic o, input logic n);
      if (t) begin
         repeat (2) @(posedge clk);
         #1 chk("miso_hold", spi_miso, o);
         @(posedge clk);
         #1 chk("miso_upd", spi_miso, n);
         repeat (HALF - 2) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic frame(input logic [1:0] m, input int nb, input int cut);
      logic       cpol, cpha, full;
      logic [7:0] ob, ib, eb;
      int         nbits, lo;
      cpol = m[1];
      cpha = m[0];
      mode = m;
      @(negedge clk);
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      mode = ~m;
      chk("busy_on", busy, 1);
      chk("oe_on", spi_miso_oe, 1);
      for (int b = 0; b < nb; b++) begin
         ob    = mo[b];
         ib    = '0;
         eb    = '0;
         nbits = (b == nb - 1 && cut > 0) ? cut : 8;
         full  = (nbits == 8);
         lo    = 8 - nbits;
         if (full) begin
            exp_rx.push_back(ob);
            if (exp_miso.size() == 0) chk("miso_unexpected", 1, 0);
            else eb = exp_miso.pop_front();
         end
         for (int i = 7; i >= lo; i--) begin
            if (!cpha) begin
               spi_mosi = ob[i];
               if (b == nb - 1 && i == lo) ul = uc;
               ib[i] = spi_miso;
               spi_sclk = ~cpol;
               half_wait(1'b0, 1'b0, 1'b0);
               spi_sclk = cpol;
               if (i > 0) half_wait(full, eb[i], eb[i-1]);
               else half_wait(1'b0, 1'b0, 1'b0);
            end else begin
               spi_sclk = ~cpol;
               spi_mosi = ob[i];
               if (i < 7) half_wait(full, eb[i+1], eb[i]);
               else half_wait(1'b0, 1'b0, 1'b0);
               if (b == nb - 1 && i == lo) ul = uc;
               ib[i] = spi_miso;
               spi_sclk = cpol;
               half_wait(1'b0, 1'b0, 1'b0);
            end
         end
         if (full) chk("miso_byte", ib, eb);
      end
      repeat (HALF) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (HALF) @(negedge clk);
      chk("busy_off", busy, 0);
      chk("oe_off", spi_miso_oe, 0);
   endtask

   task automatic run(input logic [1:0] m, input int nb, input int cut);
      idle_lvl(m);
      frame(m, nb, cut);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      mode     = 2'd0;
      spi_sclk = 1'b0;
      spi_mosi = 1'b0;
      spi_cs_n = 1'b1;
      tx_data  = '0;
      tx_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_miso", spi_miso, 0);
      chk("rst_oe", spi_miso_oe, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_underrun", tx_underrun, 0);
      chk("rst_busy", busy, 0);

      // mode 0 single byte
      wr(8'hA5);
      exp_miso.push_back(8'hA5);
      mo[0] = 8'h3C;
      u0 = uc; r0 = rxv;
      run(2'd0, 1, 0);
      chk("m0_rxv", rxv - r0, 1);
      chk("m0_underrun", ul - u0, 0);
      chk("m0_tail_underrun", uc - u0, 1);
      chk("m0_rx_hold", rx_data, 8'h3C);

      // modes 1..3
      for (int m = 1; m < 4; m++) begin
         wr(8'h81);
         exp_miso.push_back(8'h81);
         mo[0] = 8'h7E;
         u0 = uc; r0 = rxv;
         run(m[1:0], 1, 0);
         chk("mN_rxv", rxv - r0, 1);
         chk("mN_underrun", ul - u0, 0);
      end

      // 3-byte frame, third byte not supplied
      wr(8'h11);
      exp_miso.push_back(8'h11);
      exp_miso.push_back(8'h22);
      exp_miso.push_back(8'hFF);
      mo[0] = 8'hC5; mo[1] = 8'h5C; mo[2] = 8'h09;
      u0 = uc; r0 = rxv;
      idle_lvl(2'd0);
      fork
         frame(2'd0, 3, 0);
         begin
            repeat (24) @(negedge clk);
            wr(8'h22);
         end
      join
      chk("mb_rxv", rxv - r0, 3);
      chk("mb_underrun", ul - u0, 1);

      // mode 3 aborted after 5 bits, then a full frame
      mo[0] = 8'hF0;
      r0 = rxv;
      run(2'd3, 1, 5);
      chk("abort_rxv", rxv - r0, 0);
      wr(8'hC3);
      exp_miso.push_back(8'hC3);
      mo[0] = 8'h96;
      r0 = rxv;
      run(2'd3, 1, 0);
      chk("after_abort_rxv", rxv - r0, 1);

      // reset mid-byte with holding full
      idle_lvl(2'd0);
      mode = 2'd0;
      @(negedge clk);
      spi_cs_n = 1'b0;
      repeat (20) @(negedge clk);
      wr(8'h5A);
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
      repeat (HALF) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_oe", spi_miso_oe, 0);
      chk("mrst_tx_ready", tx_ready, 1);
      chk("mrst_miso", spi_miso, 0);
      chk("mrst_rx_data", rx_data, 0);
      chk("mrst_rx_valid", rx_valid, 0);
      chk("mrst_underrun", tx_underrun, 0);
      spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      exp_miso.push_back(8'hFF);
      mo[0] = 8'h24;
      u0 = uc;
      run(2'd0, 1, 0);
      chk("mrst_fill_underrun", ul - u0, 1);

      // write coincident with frame-start load on empty holding
      exp_miso.push_back(8'hFF);
      exp_miso.push_back(8'h6D);
      mo[0] = 8'hB2; mo[1] = 8'h4E;
      u0 = uc; r0 = rxv;
      idle_lvl(2'd0);
      fork
         frame(2'd0, 2, 0);
         begin
            @(negedge clk);
            repeat (2) @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = 8'h6D;
            @(negedge clk);
            tx_valid = 1'b0;
            chk("coinc_tx_ready", tx_ready, 0);
         end
      join
      chk("coinc_rxv", rxv - r0, 2);
      chk("coinc_underrun", ul - u0, 1);
      chk("sb_rx_empty", exp_rx.size(), 0);
      chk("sb_miso_empty", exp_miso.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
